// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, bus widths and state types for the pipeline controller.
package pipeline_ctrl_pkg;

    localparam int unsigned WordAddrBus = 30;
    localparam int unsigned WordDataBus = 32;
    localparam int unsigned RegAddrBus  = 5;
    localparam int unsigned IsaExpBus   = 3;

    localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
    localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
    localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

    localparam logic [IsaExpBus-1:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [IsaExpBus-1:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [IsaExpBus-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [IsaExpBus-1:0] ISA_EXP_OVERFLOW   = 3'd3;
    localparam logic [IsaExpBus-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
    localparam logic [IsaExpBus-1:0] ISA_EXP_TRAP       = 3'd5;
    localparam logic [IsaExpBus-1:0] ISA_EXP_PRV_VIO    = 3'd6;

    localparam logic CPU_KERNEL_MODE = 1'b0;
    localparam logic CPU_USER_MODE   = 1'b1;

    localparam logic [RegAddrBus-1:0] CREG_ADDR_STATUS     = 5'd0;
    localparam logic [RegAddrBus-1:0] CREG_ADDR_PRE_STATUS = 5'd1;
    localparam logic [RegAddrBus-1:0] CREG_ADDR_INT_MASK   = 5'd2;
    localparam logic [RegAddrBus-1:0] CREG_ADDR_EXP_CODE   = 5'd3;
    localparam logic [RegAddrBus-1:0] CREG_ADDR_EXP_VECTOR = 5'd4;
    localparam logic [RegAddrBus-1:0] CREG_ADDR_EPC        = 5'd5;

    typedef enum logic {StRun, StDrain} ctrl_state_e;

    // Which source drives the control-register write port this cycle.
    typedef enum logic [1:0] {CregWrNone, CregWrExp, CregWrExrt, CregWrCr} creg_wr_e;

endpackage

// File: rtl/pipeline_ctrl_creg.sv
// Control-register file: combinational read port, single write port whose
// source is exception entry, EXRT restore or a WRCR instruction.
module pipeline_ctrl_creg
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned            IRQ_CH      = 8,
    parameter logic [WordAddrBus-1:0] EXP_VEC_RST = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  creg_wr_e               wr_kind_i,
    input  logic [RegAddrBus-1:0]  wr_addr_i,
    input  logic [WordDataBus-1:0] wr_data_i,
    input  logic [WordAddrBus-1:0] exp_pc_i,
    input  logic [IsaExpBus-1:0]   exp_code_i,
    input  logic [RegAddrBus-1:0]  rd_addr_i,
    output logic [WordDataBus-1:0] rd_data_o,
    output logic                   exe_mode_o,
    output logic                   int_en_o,
    output logic [IRQ_CH-1:0]      int_mask_o,
    output logic [WordAddrBus-1:0] epc_o,
    output logic [WordAddrBus-1:0] exp_vector_o
);

    logic                   exe_mode_q, int_en_q, pre_exe_mode_q, pre_int_en_q;
    logic [IRQ_CH-1:0]      int_mask_q;
    logic [IsaExpBus-1:0]   exp_code_q;
    logic [WordAddrBus-1:0] epc_q, exp_vector_q;

    // Register update from the selected write source.
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_mode_q     <= CPU_KERNEL_MODE;
            int_en_q       <= 1'b0;
            pre_exe_mode_q <= CPU_KERNEL_MODE;
            pre_int_en_q   <= 1'b0;
            int_mask_q     <= '1;
            exp_code_q     <= ISA_EXP_NO_EXP;
            epc_q          <= '0;
            exp_vector_q   <= EXP_VEC_RST;
        end else begin
            unique case (wr_kind_i)
                CregWrExp: begin
                    epc_q          <= exp_pc_i;
                    exp_code_q     <= exp_code_i;
                    pre_exe_mode_q <= exe_mode_q;
                    pre_int_en_q   <= int_en_q;
                    exe_mode_q     <= CPU_KERNEL_MODE;
                    int_en_q       <= 1'b0;
                end
                CregWrExrt: begin
                    exe_mode_q <= pre_exe_mode_q;
                    int_en_q   <= pre_int_en_q;
                end
                CregWrCr: begin
                    case (wr_addr_i)
                        CREG_ADDR_STATUS: begin
                            exe_mode_q <= wr_data_i[0];
                            int_en_q   <= wr_data_i[1];
                        end
                        CREG_ADDR_PRE_STATUS: begin
                            pre_exe_mode_q <= wr_data_i[0];
                            pre_int_en_q   <= wr_data_i[1];
                        end
                        CREG_ADDR_INT_MASK:   int_mask_q   <= wr_data_i[IRQ_CH-1:0];
                        CREG_ADDR_EXP_CODE:   exp_code_q   <= wr_data_i[IsaExpBus-1:0];
                        CREG_ADDR_EXP_VECTOR: exp_vector_q <= wr_data_i[WordDataBus-1:2];
                        CREG_ADDR_EPC:        epc_q        <= wr_data_i[WordDataBus-1:2];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Combinational read mux; unmapped indices read zero.
    always_comb begin
        rd_data_o = '0;
        case (rd_addr_i)
            CREG_ADDR_STATUS:     rd_data_o = {30'b0, int_en_q, exe_mode_q};
            CREG_ADDR_PRE_STATUS: rd_data_o = {30'b0, pre_int_en_q, pre_exe_mode_q};
            CREG_ADDR_INT_MASK:   rd_data_o = WordDataBus'(int_mask_q);
            CREG_ADDR_EXP_CODE:   rd_data_o = WordDataBus'(exp_code_q);
            CREG_ADDR_EXP_VECTOR: rd_data_o = {exp_vector_q, 2'b00};
            CREG_ADDR_EPC:        rd_data_o = {epc_q, 2'b00};
            default:              rd_data_o = '0;
        endcase
    end

    assign exe_mode_o   = exe_mode_q;
    assign int_en_o     = int_en_q;
    assign int_mask_o   = int_mask_q;
    assign epc_o        = epc_q;
    assign exp_vector_o = exp_vector_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage stall/flush, PC redirect and control-register
// commit from the MEM stage, with a one-cycle drain after every redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned            IRQ_CH      = 8,
    parameter logic [WordAddrBus-1:0] EXP_VEC_RST = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IRQ_CH-1:0]      irq,
    output logic                   int_detect,
    input  logic                   if_busy,
    input  logic                   mem_busy,
    input  logic                   ld_hazard,
    input  logic                   mem_en,
    input  logic [WordAddrBus-1:0] mem_pc,
    input  logic [1:0]             mem_ctrl_op,
    input  logic [RegAddrBus-1:0]  mem_dst_addr,
    input  logic [WordDataBus-1:0] mem_wr_val,
    input  logic [IsaExpBus-1:0]   mem_exp_code,
    input  logic [RegAddrBus-1:0]  creg_rd_addr,
    output logic [WordDataBus-1:0] creg_rd_data,
    output logic                   exe_mode,
    output logic                   if_stall,
    output logic                   id_stall,
    output logic                   ex_stall,
    output logic                   mem_stall,
    output logic                   if_flush,
    output logic                   id_flush,
    output logic                   ex_flush,
    output logic                   mem_flush,
    output logic [WordAddrBus-1:0] new_pc
);

    ctrl_state_e            state_q, state_d;
    creg_wr_e               wr_kind;
    logic                   int_en, busy;
    logic [IRQ_CH-1:0]      int_mask;
    logic [WordAddrBus-1:0] epc, exp_vector;
    logic [IsaExpBus-1:0]   exp_code_sel;

    pipeline_ctrl_creg #(
        .IRQ_CH      (IRQ_CH),
        .EXP_VEC_RST (EXP_VEC_RST)
    ) u_creg (
        .clk          (clk),
        .reset        (reset),
        .wr_kind_i    (wr_kind),
        .wr_addr_i    (mem_dst_addr),
        .wr_data_i    (mem_wr_val),
        .exp_pc_i     (mem_pc),
        .exp_code_i   (exp_code_sel),
        .rd_addr_i    (creg_rd_addr),
        .rd_data_o    (creg_rd_data),
        .exe_mode_o   (exe_mode),
        .int_en_o     (int_en),
        .int_mask_o   (int_mask),
        .epc_o        (epc),
        .exp_vector_o (exp_vector)
    );

    assign int_detect   = int_en & (|(irq & ~int_mask));
    assign busy         = if_busy | mem_busy;
    // An interrupt taken on an instruction overrides its own exception code.
    assign exp_code_sel = int_detect ? ISA_EXP_EXT_INT : mem_exp_code;

    // Priority decode of the MEM-stage event into stalls, flushes and redirect.
    always_comb begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'b0000;
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b0000;
        new_pc  = '0;
        wr_kind = CregWrNone;
        state_d = state_q;
        if (!reset) begin
            unique case (state_q)
                StRun: begin
                    if (busy) begin
                        {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
                    end else if (mem_en && ((mem_exp_code != ISA_EXP_NO_EXP) || int_detect)) begin
                        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
                        new_pc  = exp_vector;
                        wr_kind = CregWrExp;
                        state_d = StDrain;
                    end else if (mem_en && (mem_ctrl_op == CTRL_OP_EXRT)) begin
                        {if_flush, id_flush, ex_flush} = 3'b111;
                        new_pc  = epc;
                        wr_kind = CregWrExrt;
                        state_d = StDrain;
                    end else if (mem_en && (mem_ctrl_op == CTRL_OP_WRCR)) begin
                        {if_flush, id_flush, ex_flush} = 3'b111;
                        new_pc  = mem_pc + 30'd1;
                        wr_kind = CregWrCr;
                        state_d = StDrain;
                    end else if (ld_hazard) begin
                        {if_stall, id_stall} = 2'b11;
                        ex_flush = 1'b1;
                    end
                end
                StDrain: begin
                    // The flushed MEM slot and hazard flag carry nothing valid here.
                    if (busy) begin
                        {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
